// File: rtl/c1_cycle_ctrl.sv
// 68k bus cycle controller: zone decode, wait-state insertion,
// port handshake, DTACK generation and bus-error watchdog.
module c1_cycle_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic       CLK_68KCLK,
  input  logic       nRESET,
  input  logic       nAS,
  input  logic [3:0] M68K_ADDR,
  input  logic       nROMWAIT,
  input  logic       nPWAIT0,
  input  logic       nPWAIT1,
  input  logic       PDTACK,
  output logic       nDTACK,
  output logic       nBERR,
  output logic [2:0] CYCLE_STATE
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_PACK = 3'd2,
    S_ACK  = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] wd_q, wd_d;
  logic [7:0] wd_inc;
  logic       port_q, port_d;
  logic       as_prev_q;
  logic       ndtack_q, nberr_q;

  logic       is_rom, is_port, is_card, is_sys;
  logic [1:0] n_start;
  logic       start;
  logic       w_done;
  logic       hold;

  always_comb begin
    is_rom  = (M68K_ADDR == 4'h0);
    is_port = (M68K_ADDR == 4'h2);
    is_card = (M68K_ADDR[3:2] == 2'b10);
    is_sys  = (M68K_ADDR == 4'hC);
    n_start = 2'd0;
    unique case (1'b1)
      is_rom:  n_start = {1'b0, ~nROMWAIT};
      is_port: n_start = {~nPWAIT0, ~nPWAIT1};
      is_card: n_start = 2'd2;
      is_sys:  n_start = 2'd0;
      default: n_start = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    port_d  = port_q;
    wd_inc  = wd_q + 8'd1;
    start   = ~nAS & as_prev_q;
    w_done  = (cnt_q == 2'd1);
    // hold: a port device still holding off the acknowledge
    hold    = port_q & ~PDTACK;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d  = n_start;
          port_d = is_port;
          wd_d   = 8'd0;
          if (n_start != 2'd0)
            state_d = S_WAIT;
          else if (is_port && !PDTACK)
            state_d = S_PACK;
          else
            state_d = S_ACK;
        end
      end
      S_WAIT: begin
        if (nAS) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 2'd1;
          wd_d  = wd_inc;
          if (w_done && !hold)
            state_d = S_ACK;
          else if (wd_inc == TO_LIM)
            state_d = S_ERR;
          else if (w_done)
            state_d = S_PACK;
        end
      end
      S_PACK: begin
        if (nAS) begin
          state_d = S_IDLE;
        end else begin
          wd_d = wd_inc;
          if (PDTACK)
            state_d = S_ACK;
          else if (wd_inc == TO_LIM)
            state_d = S_ERR;
        end
      end
      S_ACK, S_ERR: begin
        if (nAS)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_68KCLK) begin
    if (!nRESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= 2'd0;
      wd_q      <= 8'd0;
      port_q    <= 1'b0;
      as_prev_q <= 1'b0;
      ndtack_q  <= 1'b1;
      nberr_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wd_q      <= wd_d;
      port_q    <= port_d;
      as_prev_q <= nAS;
      ndtack_q  <= (state_d != S_ACK);
      nberr_q   <= (state_d != S_ERR);
    end
  end

  assign nDTACK      = ndtack_q;
  assign nBERR       = nberr_q;
  assign CYCLE_STATE = state_q;

endmodule

// File: tb/tb_c1_cycle_ctrl.sv
// Directed bench for c1_cycle_ctrl with a transaction-level
// timing model checked every cycle plus literal spot checks.
module tb_c1_cycle_ctrl;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       nRESET;
  logic       nAS;
  logic [3:0] addr;
  logic       nROMWAIT;
  logic       nPWAIT0;
  logic       nPWAIT1;
  logic       PDTACK;
  logic       nDTACK;
  logic       nBERR;
  logic [2:0] cs;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  c1_cycle_ctrl #(.TIMEOUT(TO)) dut (
    .CLK_68KCLK (clk),
    .nRESET     (nRESET),
    .nAS        (nAS),
    .M68K_ADDR  (addr),
    .nROMWAIT   (nROMWAIT),
    .nPWAIT0    (nPWAIT0),
    .nPWAIT1    (nPWAIT1),
    .PDTACK     (PDTACK),
    .nDTACK     (nDTACK),
    .nBERR      (nBERR),
    .CYCLE_STATE(cs)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a bus cycle is described by its start edge, wait count
  // and zone; state follows from elapsed edges and sampled inputs.
  int  edge_n  = 0;
  bit  m_busy  = 1'b0;
  bit  m_prev  = 1'b0;
  bit  m_acked = 1'b0;
  bit  m_err   = 1'b0;
  bit  m_port  = 1'b0;
  int  m_start = 0;
  int  m_n     = 0;
  int  m_el    = 0;

  function automatic int waits_for(input logic [3:0] a, input logic rw,
                                   input logic p0, input logic p1);
    int v;
    v = int'(a);
    if (v == 0) return rw ? 0 : 1;
    if (v == 2) return (p0 ? 0 : 2) + (p1 ? 0 : 1);
    if (v >= 8 && v <= 11) return 2;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (!nRESET) begin
      m_busy  = 1'b0;
      m_acked = 1'b0;
      m_err   = 1'b0;
      m_prev  = 1'b0;
    end else begin
      if (!m_busy) begin
        if (!nAS && m_prev) begin
          m_busy  = 1'b1;
          m_start = edge_n;
          m_el    = 0;
          m_port  = (addr == 4'h2);
          m_n     = waits_for(addr, nROMWAIT, nPWAIT0, nPWAIT1);
          m_err   = 1'b0;
          m_acked = (m_n == 0) && !(m_port && !PDTACK);
        end
      end else if (nAS) begin
        m_busy = 1'b0;
      end else if (!m_acked && !m_err) begin
        m_el = edge_n - m_start;
        if (m_el >= m_n && (!m_port || PDTACK)) m_acked = 1'b1;
        else if (m_el >= TO) m_err = 1'b1;
      end
      m_prev = nAS;
    end
    edge_n++;
  end

  function automatic int model_state();
    if (!m_busy) return 0;
    if (m_err) return 4;
    if (m_acked) return 3;
    if (m_el < m_n) return 1;
    return 2;
  endfunction

  always @(negedge clk) begin
    if (started) begin
      chk("model_state", int'(cs), model_state());
      chk("model_dtack", int'(nDTACK), (model_state() == 3) ? 0 : 1);
      chk("model_berr", int'(nBERR), (model_state() == 4) ? 0 : 1);
      if (!nDTACK && !nBERR) chk("both_low", 1, 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input int s, input int d,
                     input int b);
    chk({name, "_state"}, int'(cs), s);
    chk({name, "_dtack"}, int'(nDTACK), d);
    chk({name, "_berr"}, int'(nBERR), b);
  endtask

  task automatic idle_step();
    nAS = 1'b1;
    PDTACK = 1'b0;
    step();
  endtask

  initial begin
    nRESET = 1'b0; nAS = 1'b1; addr = 4'h0; nROMWAIT = 1'b1;
    nPWAIT0 = 1'b1; nPWAIT1 = 1'b1; PDTACK = 1'b0;
    step();
    step();
    started = 1'b1;
    lit("reset", 0, 1, 1);
    nRESET = 1'b1;
    step();

    // system ROM: zero waits
    addr = 4'hC; nAS = 1'b0; step();
    lit("sys_k", 3, 0, 1);
    step();
    lit("sys_hold", 3, 0, 1);
    idle_step();
    lit("sys_rel", 0, 1, 1);

    // card: two waits, late address/wait changes ignored
    addr = 4'h8; nAS = 1'b0; step();
    lit("card_k", 1, 1, 1);
    addr = 4'hF; nROMWAIT = 1'b0; step();
    lit("card_k1", 1, 1, 1);
    step();
    lit("card_k2", 3, 0, 1);
    idle_step();
    lit("card_rel", 0, 1, 1);

    // ROM with one wait
    addr = 4'h0; nROMWAIT = 1'b0; nAS = 1'b0; step();
    lit("rom_k", 1, 1, 1);
    step();
    lit("rom_k1", 3, 0, 1);
    idle_step();
    nROMWAIT = 1'b1;

    // port, N=2, device ready at k+5
    addr = 4'h2; nPWAIT0 = 1'b0; nPWAIT1 = 1'b1; nAS = 1'b0; step();
    lit("port_k", 1, 1, 1);
    step();
    step();
    lit("port_k2", 2, 1, 1);
    step();
    step();
    lit("port_k4", 2, 1, 1);
    PDTACK = 1'b1; step();
    lit("port_k5", 3, 0, 1);
    idle_step();

    // port stuck: watchdog fires at k+8
    nAS = 1'b0; step();
    for (int i = 0; i < 7; i++) step();
    lit("wd_k7", 2, 1, 1);
    step();
    lit("wd_k8", 4, 1, 0);
    step();
    lit("wd_hold", 4, 1, 0);
    idle_step();
    lit("wd_rel", 0, 1, 1);

    // ready on the same edge as the watchdog limit: ACK wins
    nAS = 1'b0; step();
    for (int i = 0; i < 7; i++) step();
    PDTACK = 1'b1; step();
    lit("wd_tie", 3, 0, 1);
    idle_step();
    nPWAIT0 = 1'b1;

    // abort during card wait
    addr = 4'h8; nAS = 1'b0; step();
    step();
    lit("abort_k1", 1, 1, 1);
    idle_step();
    lit("abort", 0, 1, 1);

    // reset during ACK with nAS held low
    addr = 4'hC; nAS = 1'b0; step();
    lit("rst_ack", 3, 0, 1);
    nRESET = 1'b0; step();
    lit("rst_edge", 0, 1, 1);
    nRESET = 1'b1; step();
    lit("rst_nostart", 0, 1, 1);
    step();
    lit("rst_nostart2", 0, 1, 1);
    nAS = 1'b1; step();
    nAS = 1'b0; step();
    lit("rst_restart", 3, 0, 1);
    idle_step();

    // other zone and zero-wait port variants
    addr = 4'h5; nAS = 1'b0; step();
    lit("other", 3, 0, 1);
    idle_step();
    addr = 4'h2; PDTACK = 1'b1; nAS = 1'b0; step();
    lit("port0_rdy", 3, 0, 1);
    idle_step();
    nAS = 1'b0; step();
    lit("port0_pack", 2, 1, 1);
    PDTACK = 1'b1; step();
    lit("port0_ack", 3, 0, 1);
    idle_step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
